// File: rtl/stream_topk_tracker.sv
`default_nettype none
// ============================================================================
// Module   : stream_topk_tracker
// Purpose  : Tracks the K largest unsigned samples of a qualified stream,
//            reports the K-th largest and allows readback of any rank.
//            Also keeps a saturating count of accepted samples.
// Revision : 1.0 - initial release
// ============================================================================
module stream_topk_tracker #(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 4,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clr,
   input  logic                     din_valid,
   input  logic [DATA_WIDTH-1:0]    din,
   input  logic [$clog2(K)-1:0]     rank_sel,
   output logic [DATA_WIDTH-1:0]    kth_out,
   output logic                     kth_valid,
   output logic [DATA_WIDTH-1:0]    rank_out,
   output logic                     rank_valid,
   output logic [CNT_W-1:0]         count
);

   localparam int c_sel_w = $clog2(K);
   localparam int c_occ_w = $clog2(K + 1);

   // Sorted table, largest in slot 0; only slots below r_occ hold samples.
   logic [DATA_WIDTH-1:0] r_top [K];
   logic [c_occ_w-1:0]    r_occ;
   logic [CNT_W-1:0]      r_count;

   // w_ge marks filled slots that stay ahead of din; it is always a prefix
   // because the table is sorted, so its length is the insert position.
   logic [K-1:0]          w_ge;
   logic [DATA_WIDTH-1:0] w_next [K];

   logic [DATA_WIDTH-1:0] w_rank_out;
   logic                  w_rank_valid;

   // Per-slot next value: keep if ahead of din, take din at the insert
   // position, otherwise shift down from the slot above.
   for (genvar i = 0; i < K; i++) begin : g_slot
      assign w_ge[i] = (c_occ_w'(i) < r_occ) && (r_top[i] >= din);
      if (i == 0) begin : g_head
         assign w_next[i] = w_ge[i] ? r_top[i] : din;
      end else begin : g_tail
         assign w_next[i] = w_ge[i]   ? r_top[i] :
                            w_ge[i-1] ? din      : r_top[i-1];
      end
   end

   // Table, occupancy and sample-count update; reset and clear win over data.
   always_ff @(posedge clk) begin
      if (!resetn || clr) begin
         for (int i = 0; i < K; i++) begin
            r_top[i] <= '0;
         end
         r_occ   <= '0;
         r_count <= '0;
      end else if (din_valid) begin
         for (int i = 0; i < K; i++) begin
            r_top[i] <= w_next[i];
         end
         if (r_occ != c_occ_w'(K)) begin
            r_occ <= r_occ + c_occ_w'(1);
         end
         if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   // Rank readback; selections at or beyond K (or beyond occupancy) give zero.
   always_comb begin
      w_rank_out   = '0;
      w_rank_valid = 1'b0;
      for (int i = 0; i < K; i++) begin
         if ((rank_sel == c_sel_w'(i)) && (c_occ_w'(i) < r_occ)) begin
            w_rank_out   = r_top[i];
            w_rank_valid = 1'b1;
         end
      end
   end

   assign kth_valid  = (r_occ == c_occ_w'(K));
   assign kth_out    = kth_valid ? r_top[K-1] : '0;
   assign rank_out   = w_rank_out;
   assign rank_valid = w_rank_valid;
   assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_topk_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_topk_tracker
// Purpose  : Scoreboard bench for stream_topk_tracker (K=3, CNT_W=3, 8-bit
//            data). A sorted-queue reference model predicts each cycle's
//            outputs; a monitor pops and compares one entry per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_topk_tracker;

   localparam int DW     = 8;
   localparam int KK     = 3;
   localparam int CW     = 3;
   localparam int SW     = $clog2(KK);
   localparam int CMAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          clr = 1'b0;
   logic          din_valid = 1'b0;
   logic [DW-1:0] din = '0;
   logic [SW-1:0] rank_sel = '0;
   logic [DW-1:0] kth_out;
   logic          kth_valid;
   logic [DW-1:0] rank_out;
   logic          rank_valid;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned kth;
      int unsigned kthv;
      int unsigned rank;
      int unsigned rankv;
      int unsigned cnt;
   } exp_t;

   exp_t        sbq[$];
   int unsigned mq[$];     // reference table, descending
   int unsigned mcnt = 0;

   stream_topk_tracker #(
      .DATA_WIDTH (DW),
      .K          (KK),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .clr        (clr),
      .din_valid  (din_valid),
      .din        (din),
      .rank_sel   (rank_sel),
      .kth_out    (kth_out),
      .kth_valid  (kth_valid),
      .rank_out   (rank_out),
      .rank_valid (rank_valid),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: insert at the count of entries >= d, keep top K.
   task automatic model_insert(input int unsigned d);
      int p = 0;
      foreach (mq[i]) if (mq[i] >= d) p++;
      if (p < KK) begin
         mq.insert(p, d);
         if (mq.size() > KK) void'(mq.pop_back());
      end
      if (mcnt < CMAX) mcnt++;
   endtask

   // One stimulus cycle: drive at negedge, advance model, queue expectation.
   task automatic cyc(input logic rn, input logic cl, input logic v,
                      input int unsigned d, input int unsigned sel);
      exp_t e;
      @(negedge clk);
      resetn    = rn;
      clr       = cl;
      din_valid = v;
      din       = DW'(d);
      rank_sel  = SW'(sel);
      if (!rn || cl) begin
         mq.delete();
         mcnt = 0;
      end else if (v) begin
         model_insert(d);
      end
      e.kthv  = (mq.size() == KK) ? 1 : 0;
      e.kth   = e.kthv ? mq[KK-1] : 0;
      e.rankv = (sel < mq.size()) ? 1 : 0;
      e.rank  = e.rankv ? mq[sel] : 0;
      e.cnt   = mcnt;
      sbq.push_back(e);
   endtask

   task automatic samp(input int unsigned d, input int unsigned sel);
      cyc(1'b1, 1'b0, 1'b1, d, sel);
   endtask

   // Monitor: every edge after which a response is due, compare it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("kth_out",    32'(kth_out),    e.kth);
            chk("kth_valid",  32'(kth_valid),  e.kthv);
            chk("rank_out",   32'(rank_out),   e.rank);
            chk("rank_valid", 32'(rank_valid), e.rankv);
            chk("count",      32'(count),      e.cnt);
         end
      end
   end

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset with a valid sample present: must be dropped
      cyc(1'b0, 1'b0, 1'b1, 50, 0);
      cyc(1'b0, 1'b0, 1'b0, 0, 0);

      // ascending/descending mix with rank sweeps
      samp(5, 0); samp(3, 1); samp(9, 2);
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0, 0, 1);
      cyc(1'b1, 1'b0, 1'b0, 0, 3);   // out-of-range rank

      // duplicates
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      samp(7, 2); samp(7, 2); samp(7, 2); samp(2, 2); samp(7, 1);

      // zeros are real samples
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      samp(0, 1); samp(0, 1); samp(0, 2);

      // gaps hold state
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      samp(10, 0);
      cyc(1'b1, 1'b0, 1'b0, 77, 0);
      samp(40, 0);
      cyc(1'b1, 1'b0, 1'b0, 99, 1);
      samp(20, 1); samp(30, 2);
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0, 0, 1);
      cyc(1'b1, 1'b0, 1'b0, 0, 2);

      // clear with valid sample, then restart
      samp(8, 0); samp(6, 1);
      cyc(1'b1, 1'b1, 1'b1, 99, 0);
      samp(4, 0); samp(1, 1); samp(3, 2);

      // same through reset
      samp(8, 0); samp(6, 1);
      cyc(1'b0, 1'b0, 1'b1, 99, 0);
      samp(4, 0); samp(1, 1); samp(3, 2);

      // saturation: 10 samples, count sticks at 7
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 10; i++) samp(i * 3, 3);

      // boundary values
      samp(255, 0); samp(255, 1); samp(0, 2);

      // randomized traffic with occasional clear/reset
      for (int i = 0; i < 600; i++) begin
         int unsigned r  = $urandom_range(0, 99);
         int unsigned d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                        : $urandom_range(0, 15);
         int unsigned s  = $urandom_range(0, 3);
         logic        rn = (r != 0);
         logic        cl = (r == 1) || (r == 2);
         logic        v  = ($urandom_range(0, 3) != 0);
         cyc(rn, cl, v, d, s);
      end

      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
